// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary-to-BCD converter with overflow and signed input
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bcd_sh;
    logic [BW-1:0]    bcd_adj;
    logic [WIDTH-1:0] mag_sh;
    logic [WIDTH-1:0] mag_load;
    logic             in_neg;
    logic             ovf;
    logic             neg_r;
    logic             nz_r;

    // Operand is negative only when signed mode is enabled and its MSB is set
    always_comb begin
        in_neg = (SIGNED != 0) && bin_in[WIDTH-1];
    end

    // Magnitude as a WIDTH-bit unsigned value; the most negative input maps to 2**(WIDTH-1)
    always_comb begin
        mag_load = in_neg ? (~bin_in + WIDTH'(1)) : bin_in;
    end

    // Add 3 to every digit holding 5..9 so the following left shift carries correctly
    always_comb begin
        bcd_adj = bcd_sh;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_sh[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_sh[4*k +: 4] + 4'd3;
            end
        end
    end

    // Control FSM and datapath: load, WIDTH shift iterations, then publish results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bcd_sh   <= '0;
            mag_sh   <= '0;
            ovf      <= 1'b0;
            neg_r    <= 1'b0;
            nz_r     <= 1'b0;
            bcd_out  <= '0;
            sign     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mag_sh <= mag_load;
                        neg_r  <= in_neg;
                        // Nonzero test is taken on the loaded magnitude, since the
                        // shift register is drained to zero by the time DONE is reached
                        nz_r   <= |mag_load;
                        bcd_sh <= '0;
                        ovf    <= 1'b0;
                        cnt    <= CW'(WIDTH);
                        state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd_sh <= {bcd_adj[BW-2:0], mag_sh[WIDTH-1]};
                    mag_sh <= {mag_sh[WIDTH-2:0], 1'b0};
                    ovf    <= ovf | bcd_adj[BW-1];
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd_out  <= bcd_sh;
                    sign     <= neg_r & nz_r;
                    overflow <= ovf;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake status is a pure decode of the state register
    always_comb begin
        ready = (state == S_IDLE);
        busy  = ~ready;
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed vector bench for bin2bcd_seq across four parameterisations
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start_v [4];
    logic [15:0] bin_v   [4];

    logic [11:0] bcd0;
    logic [19:0] bcd1;
    logic [7:0]  bcd2;
    logic [11:0] bcd3;
    logic [19:0] bcd_w   [4];
    logic        rdy_w   [4];
    logic        busy_w  [4];
    logic        done_w  [4];
    logic        sign_w  [4];
    logic        ovf_w   [4];

    int n_tests = 0;
    int n_fail  = 0;

    // inst 0: W8 D3 unsigned, inst 1: W16 D5, inst 2: W8 D2, inst 3: W8 D3 signed
    bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bin_in(bin_v[0][7:0]),
        .ready(rdy_w[0]), .busy(busy_w[0]), .done(done_w[0]), .bcd_out(bcd0),
        .sign(sign_w[0]), .overflow(ovf_w[0]));
    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bin_in(bin_v[1]),
        .ready(rdy_w[1]), .busy(busy_w[1]), .done(done_w[1]), .bcd_out(bcd1),
        .sign(sign_w[1]), .overflow(ovf_w[1]));
    bin2bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .bin_in(bin_v[2][7:0]),
        .ready(rdy_w[2]), .busy(busy_w[2]), .done(done_w[2]), .bcd_out(bcd2),
        .sign(sign_w[2]), .overflow(ovf_w[2]));
    bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .bin_in(bin_v[3][7:0]),
        .ready(rdy_w[3]), .busy(busy_w[3]), .done(done_w[3]), .bcd_out(bcd3),
        .sign(sign_w[3]), .overflow(ovf_w[3]));

    assign bcd_w[0] = {8'h00, bcd0};
    assign bcd_w[1] = bcd1;
    assign bcd_w[2] = {12'h000, bcd2};
    assign bcd_w[3] = {8'h00, bcd3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic [15:0] val;
        logic [19:0] bcd;
        logic        sgn;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts a conversion on the next negedge, returns in the cycle where done is seen
    task automatic do_conv(input int inst, input logic [15:0] val, output int lat,
                           output logic rdy_at_done);
        @(negedge clk);
        start_v[inst] = 1'b1;
        bin_v[inst]   = val;
        @(posedge clk);
        #1;
        start_v[inst] = 1'b0;
        bin_v[inst]   = 16'h0;
        lat = 0;
        while (!done_w[inst] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdy_at_done = rdy_w[inst];
    endtask

    initial begin
        int   lat;
        logic rdy;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;
            bin_v[i]   = 16'h0;
        end

        vecs.push_back('{0, 16'd255,   20'h00255, 1'b0, 1'b0, 9});
        vecs.push_back('{0, 16'd0,     20'h00000, 1'b0, 1'b0, 9});
        vecs.push_back('{0, 16'd9,     20'h00009, 1'b0, 1'b0, 9});
        vecs.push_back('{0, 16'd128,   20'h00128, 1'b0, 1'b0, 9});
        vecs.push_back('{0, 16'd37,    20'h00037, 1'b0, 1'b0, 9});
        vecs.push_back('{1, 16'd65535, 20'h65535, 1'b0, 1'b0, 17});
        vecs.push_back('{1, 16'd1000,  20'h01000, 1'b0, 1'b0, 17});
        vecs.push_back('{1, 16'd0,     20'h00000, 1'b0, 1'b0, 17});
        vecs.push_back('{2, 16'd99,    20'h00099, 1'b0, 1'b0, 9});
        vecs.push_back('{2, 16'd100,   20'h00000, 1'b0, 1'b1, 9});
        vecs.push_back('{2, 16'd10,    20'h00010, 1'b0, 1'b0, 9});
        vecs.push_back('{2, 16'd255,   20'h00000, 1'b0, 1'b1, 9});
        vecs.push_back('{3, 16'h0080,  20'h00128, 1'b1, 1'b0, 9});
        vecs.push_back('{3, 16'h00FF,  20'h00001, 1'b1, 1'b0, 9});
        vecs.push_back('{3, 16'h007F,  20'h00127, 1'b0, 1'b0, 9});
        vecs.push_back('{3, 16'h0000,  20'h00000, 1'b0, 1'b0, 9});
        vecs.push_back('{3, 16'h009C,  20'h00100, 1'b1, 1'b0, 9});
        vecs.push_back('{3, 16'h00F6,  20'h00010, 1'b1, 1'b0, 9});

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst%0d bcd", i),   bcd_w[i],  32'h0);
            check($sformatf("rst%0d ready", i), rdy_w[i],  32'h1);
            check($sformatf("rst%0d busy", i),  busy_w[i], 32'h0);
            check($sformatf("rst%0d done", i),  done_w[i], 32'h0);
            check($sformatf("rst%0d sign", i),  sign_w[i], 32'h0);
            check($sformatf("rst%0d ovf", i),   ovf_w[i],  32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            do_conv(vecs[i].inst, vecs[i].val, lat, rdy);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d ready_at_done", i), rdy, 32'h1);
            check($sformatf("vec%0d ovf", i), ovf_w[vecs[i].inst], vecs[i].ovf);
            check($sformatf("vec%0d sign", i), sign_w[vecs[i].inst], vecs[i].sgn);
            if (!vecs[i].ovf) begin
                check($sformatf("vec%0d bcd", i), bcd_w[vecs[i].inst], vecs[i].bcd);
            end
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done_one_cycle", i), done_w[vecs[i].inst], 32'h0);
        end

        // Back-to-back: second start issued in the done cycle of the first
        do_conv(0, 16'd0, lat, rdy);
        check("b2b first bcd", bcd_w[0], 32'h000);
        check("b2b first sign", sign_w[0], 32'h0);
        do_conv(0, 16'd9, lat, rdy);
        check("b2b second latency", lat, 32'd9);
        check("b2b second bcd", bcd_w[0], 32'h009);

        // Start pulsed at E5 of a 16-bit conversion is ignored; outputs hold during CONV
        do_conv(1, 16'd12345, lat, rdy);
        check("hold pre bcd", bcd_w[1], 32'h12345);
        @(negedge clk);
        start_v[1] = 1'b1;
        bin_v[1]   = 16'd65535;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        bin_v[1]   = 16'h0;
        lat = 0;
        while (!done_w[1] && lat < 100) begin
            if (lat == 4) begin
                start_v[1] = 1'b1;
                bin_v[1]   = 16'd7;
            end
            @(posedge clk);
            #1;
            lat++;
            if (lat == 5) begin
                start_v[1] = 1'b0;
                bin_v[1]   = 16'h0;
                check("ign busy at E5", busy_w[1], 32'h1);
                check("ign bcd held in CONV", bcd_w[1], 32'h12345);
            end
        end
        check("ign latency", lat, 32'd17);
        check("ign bcd", bcd_w[1], 32'h65535);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("ign no requeue busy", busy_w[1], 32'h0);
        end

        // Reset asserted at E4 aborts the conversion with no done
        do_conv(0, 16'd200, lat, rdy);
        check("pre-reset bcd", bcd_w[0], 32'h200);
        @(negedge clk);
        start_v[0] = 1'b1;
        bin_v[0]   = 16'd77;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort bcd", bcd_w[0], 32'h0);
        check("abort ready", rdy_w[0], 32'h1);
        check("abort busy", busy_w[0], 32'h0);
        check("abort done", done_w[0], 32'h0);
        check("abort other inst bcd", bcd_w[1], 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            check("abort no done", done_w[0], 32'h0);
        end
        do_conv(0, 16'd42, lat, rdy);
        check("post-reset latency", lat, 32'd9);
        check("post-reset bcd", bcd_w[0], 32'h042);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
